// File: rtl/battle_pkg.sv
// Shared codes for the battle game: pages, decoded keys, player-core opcodes and move directions.
package battle_pkg;

  typedef enum logic [3:0] {
    PAGE_MENU   = 4'h1,
    PAGE_WIN    = 4'h2,
    PAGE_LOSE   = 4'h3,
    PAGE_DODGE  = 4'h9,
    PAGE_ACTION = 4'hA,
    PAGE_ATTACK = 4'hB,
    PAGE_CHECK  = 4'hC
  } page_t;

  typedef enum logic [3:0] {
    KEY_NONE  = 4'd0,
    KEY_W     = 4'd1,
    KEY_A     = 4'd2,
    KEY_S     = 4'd3,
    KEY_D     = 4'd4,
    KEY_J     = 4'd5,
    KEY_K     = 4'd6,
    KEY_L     = 4'd7,
    KEY_SPACE = 4'd8
  } key_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_HPY = 4'd1,
    OP_DPY = 4'd2,
    OP_IDG = 4'd3,
    OP_SDG = 4'd4,
    OP_MOV = 4'd5,
    OP_SHP = 4'd6
  } op_t;

  localparam logic [7:0] DIR_UP    = 8'd0;
  localparam logic [7:0] DIR_LEFT  = 8'd1;
  localparam logic [7:0] DIR_DOWN  = 8'd2;
  localparam logic [7:0] DIR_RIGHT = 8'd3;

  function automatic logic [15:0] make_instr(input op_t op, input logic [7:0] arg);
    return {op, arg, 4'h0};
  endfunction

  function automatic logic is_dir_key(input key_t k);
    return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
  endfunction

  function automatic logic [7:0] dir_of(input key_t k);
    logic [7:0] d;
    d = DIR_UP;
    case (k)
      KEY_A:   d = DIR_LEFT;
      KEY_S:   d = DIR_DOWN;
      KEY_D:   d = DIR_RIGHT;
      default: d = DIR_UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Registers the decoded key and flags a press edge: a non-zero key that differs from last cycle.
module key_edge
  import battle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  output key_t       key_level,
  output logic       key_press
);

  logic [3:0] key_q;

  always_ff @(posedge clk) begin
    if (reset) key_q <= 4'd0;
    else       key_q <= key;
  end

  assign key_level = key_t'(key);
  assign key_press = (key != 4'd0) && (key != key_q);

endmodule

// File: rtl/battle_sequencer.sv
// Turn sequencer for the battle game: walks menu/dodge/action/attack/check/end pages on 1 Hz ticks
// and drives the player core, attack bar and bullet engine from registered outputs.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int HP_W        = 8,
  parameter int MON_HP_MAX  = 100,
  parameter int PLAYER_HP   = 100,
  parameter int HEAL_AMT    = 10,
  parameter int MENU_HOLD   = 3,
  parameter int DODGE_TIME  = 7,
  parameter int ATK_TIME    = 4,
  parameter int END_TIME    = 3,
  parameter int SPARE_TURNS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [3:0]      key,
  input  logic            is_death,
  input  logic            dmg_complete,
  input  logic [HP_W-1:0] damage,
  input  logic            heal,
  input  logic            atk_pass,
  input  logic [HP_W-1:0] dmg_mon,
  output logic [7:0]      state,
  output logic [15:0]     player_instr,
  output logic            is_move,
  output logic            start_dmg,
  output logic [HP_W-1:0] mon_hp,
  output logic            atk_start,
  output logic            atk_button,
  output logic            atk_reset,
  output logic            bullet_run,
  output logic            mercy
);

  localparam logic [7:0]  MENU_HOLD_T  = 8'(MENU_HOLD);
  localparam logic [7:0]  DODGE_T      = 8'(DODGE_TIME);
  localparam logic [7:0]  ATK_T        = 8'(ATK_TIME);
  localparam logic [7:0]  END_T        = 8'(END_TIME);
  localparam logic [3:0]  SPARE_T      = 4'(SPARE_TURNS);
  localparam logic [7:0]  PLAYER_ARG   = 8'(PLAYER_HP);
  localparam logic [7:0]  HEAL_ARG     = 8'(HEAL_AMT);
  localparam logic [HP_W:0] MON_MAX_W  = (HP_W+1)'(MON_HP_MAX);

  page_t       page;
  logic [7:0]  timer;
  logic [3:0]  turns;
  logic        check_done;
  key_t        key_level;
  logic        key_press;
  logic [HP_W:0]   hp_sum;
  logic [HP_W-1:0] hp_next;

  key_edge u_key_edge (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .key_level (key_level),
    .key_press (key_press)
  );

  // One extra bit on the sum so a large hit cannot wrap past the kill threshold.
  assign hp_sum  = {1'b0, mon_hp} + {1'b0, dmg_mon};
  assign hp_next = (hp_sum >= MON_MAX_W) ? MON_MAX_W[HP_W-1:0] : hp_sum[HP_W-1:0];

  assign state = {page, 4'h0};

  always_ff @(posedge clk) begin
    if (reset) begin
      page         <= PAGE_MENU;
      timer        <= 8'd0;
      turns        <= 4'd0;
      check_done   <= 1'b0;
      player_instr <= 16'h0000;
      is_move      <= 1'b0;
      start_dmg    <= 1'b0;
      mon_hp       <= '0;
      atk_start    <= 1'b0;
      atk_button   <= 1'b0;
      atk_reset    <= 1'b1;
      bullet_run   <= 1'b0;
      mercy        <= 1'b0;
    end else begin
      player_instr <= 16'h0000;
      is_move      <= 1'b0;
      start_dmg    <= 1'b0;
      if (tick && (timer != 8'hFF)) timer <= timer + 8'd1;
      if (check_done && (turns >= SPARE_T)) mercy <= 1'b1;

      // Every branch that changes page also clears the timer, overriding the tick count above.
      case (page)
        PAGE_MENU: begin
          if (key_press && (key_level == KEY_SPACE) && (timer >= MENU_HOLD_T)) begin
            page         <= PAGE_DODGE;
            timer        <= 8'd0;
            mon_hp       <= '0;
            mercy        <= 1'b0;
            turns        <= 4'd0;
            check_done   <= 1'b0;
            player_instr <= make_instr(OP_SHP, PLAYER_ARG);
            atk_reset    <= 1'b1;
            bullet_run   <= 1'b1;
          end
        end

        PAGE_DODGE: begin
          if (is_death) begin
            page       <= PAGE_LOSE;
            timer      <= 8'd0;
            bullet_run <= 1'b0;
          end else if (timer >= DODGE_T) begin
            page       <= PAGE_ACTION;
            timer      <= 8'd0;
            bullet_run <= 1'b0;
            if (turns != 4'hF) turns <= turns + 4'd1;
          end else if (dmg_complete) begin
            player_instr <= heal ? make_instr(OP_HPY, HEAL_ARG)
                                 : make_instr(OP_DPY, 8'(damage));
            start_dmg    <= 1'b1;
          end else if (is_dir_key(key_level)) begin
            player_instr <= make_instr(OP_MOV, dir_of(key_level));
            is_move      <= 1'b1;
          end
        end

        PAGE_ACTION: begin
          if (key_press) begin
            case (key_level)
              KEY_J: begin
                page       <= PAGE_ATTACK;
                timer      <= 8'd0;
                atk_start  <= 1'b1;
                atk_reset  <= 1'b0;
                atk_button <= 1'b0;
              end
              KEY_K: begin
                page  <= PAGE_CHECK;
                timer <= 8'd0;
              end
              KEY_L: begin
                timer <= 8'd0;
                if (mercy) begin
                  page <= PAGE_WIN;
                end else begin
                  page       <= PAGE_DODGE;
                  bullet_run <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        PAGE_CHECK: begin
          check_done <= 1'b1;
          turns      <= 4'd0;
          if (key_press && (key_level == KEY_SPACE)) begin
            page       <= PAGE_DODGE;
            timer      <= 8'd0;
            bullet_run <= 1'b1;
          end
        end

        PAGE_ATTACK: begin
          if (atk_pass) begin
            mon_hp     <= hp_next;
            timer      <= 8'd0;
            atk_start  <= 1'b0;
            atk_button <= 1'b0;
            atk_reset  <= 1'b1;
            if (hp_sum >= MON_MAX_W) begin
              page <= PAGE_WIN;
            end else begin
              page       <= PAGE_DODGE;
              bullet_run <= 1'b1;
            end
          end else if (timer >= ATK_T) begin
            page       <= PAGE_DODGE;
            timer      <= 8'd0;
            bullet_run <= 1'b1;
            atk_start  <= 1'b0;
            atk_button <= 1'b0;
            atk_reset  <= 1'b1;
          end else if (key_press && (key_level == KEY_SPACE)) begin
            atk_button <= 1'b1;
          end
        end

        PAGE_WIN, PAGE_LOSE: begin
          bullet_run <= 1'b0;
          if (timer >= END_T) begin
            page  <= PAGE_MENU;
            timer <= 8'd0;
          end
        end

        default: begin
          page         <= PAGE_MENU;
          timer        <= 8'd0;
          turns        <= 4'd0;
          check_done   <= 1'b0;
          player_instr <= 16'h0000;
          mon_hp       <= '0;
          atk_start    <= 1'b0;
          atk_button   <= 1'b0;
          atk_reset    <= 1'b1;
          bullet_run   <= 1'b0;
          mercy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer: a page-level game model checked every cycle, plus literal pins.
module tb_battle_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] key = 4'd0;
  logic       is_death = 1'b0;
  logic       dmg_complete = 1'b0;
  logic [7:0] damage = 8'd0;
  logic       heal = 1'b0;
  logic       atk_pass = 1'b0;
  logic [7:0] dmg_mon = 8'd0;

  logic [7:0]  state;
  logic [15:0] player_instr;
  logic        is_move, start_dmg, atk_start, atk_button, atk_reset, bullet_run, mercy;
  logic [7:0]  mon_hp;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  battle_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .key          (key),
    .is_death     (is_death),
    .dmg_complete (dmg_complete),
    .damage       (damage),
    .heal         (heal),
    .atk_pass     (atk_pass),
    .dmg_mon      (dmg_mon),
    .state        (state),
    .player_instr (player_instr),
    .is_move      (is_move),
    .start_dmg    (start_dmg),
    .mon_hp       (mon_hp),
    .atk_start    (atk_start),
    .atk_button   (atk_button),
    .atk_reset    (atk_reset),
    .bullet_run   (bullet_run),
    .mercy        (mercy)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
    end
  endtask

  // Game model: pages are numbered by their display code, instructions built as op*4096 + arg*16.
  int m_page, m_timer, m_turns, m_prev_key, m_mon;
  bit m_check, m_mercy;
  int e_instr;
  bit e_move, e_sdmg, e_start, e_button, e_areset, e_brun;

  always @(posedge clk) begin
    int  nxt;
    bit  press;
    bit  mercy_before;
    if (reset) begin
      m_page = 1; m_timer = 0; m_turns = 0; m_prev_key = 0; m_mon = 0;
      m_check = 0; m_mercy = 0;
      e_instr = 0; e_move = 0; e_sdmg = 0; e_start = 0; e_button = 0; e_areset = 1; e_brun = 0;
    end else begin
      press = (key != 0) && (int'(key) != m_prev_key);
      m_prev_key = int'(key);
      nxt = m_page;
      e_instr = 0; e_move = 0; e_sdmg = 0;
      mercy_before = m_mercy;
      if (m_check && m_turns >= 2) m_mercy = 1;
      if (m_page == 1) begin
        if (press && key == 8 && m_timer >= 3) begin
          nxt = 9; m_mon = 0; m_mercy = 0; m_turns = 0; m_check = 0;
          e_instr = 6 * 4096 + 100 * 16; e_areset = 1; e_brun = 1;
        end
      end else if (m_page == 9) begin
        if (is_death) begin
          nxt = 3; e_brun = 0;
        end else if (m_timer >= 7) begin
          nxt = 10; e_brun = 0;
          if (m_turns < 15) m_turns = m_turns + 1;
        end else if (dmg_complete) begin
          e_instr = heal ? (1 * 4096 + 10 * 16) : (2 * 4096 + int'(damage) * 16);
          e_sdmg = 1;
        end else if (key >= 1 && key <= 4) begin
          e_instr = 5 * 4096 + (int'(key) - 1) * 16;
          e_move = 1;
        end
      end else if (m_page == 10) begin
        if (press && key == 5) begin
          nxt = 11; e_start = 1; e_areset = 0; e_button = 0;
        end else if (press && key == 6) begin
          nxt = 12;
        end else if (press && key == 7) begin
          if (mercy_before) nxt = 2;
          else begin nxt = 9; e_brun = 1; end
        end
      end else if (m_page == 12) begin
        m_check = 1; m_turns = 0;
        if (press && key == 8) begin nxt = 9; e_brun = 1; end
      end else if (m_page == 11) begin
        if (atk_pass) begin
          m_mon = (m_mon + int'(dmg_mon) > 100) ? 100 : m_mon + int'(dmg_mon);
          if (m_mon >= 100) nxt = 2;
          else begin nxt = 9; e_brun = 1; end
          e_start = 0; e_button = 0; e_areset = 1;
        end else if (m_timer >= 4) begin
          nxt = 9; e_brun = 1;
          e_start = 0; e_button = 0; e_areset = 1;
        end else if (press && key == 8) begin
          e_button = 1;
        end
      end else begin
        e_brun = 0;
        if (m_timer >= 3) nxt = 1;
      end
      if (nxt != m_page) m_timer = 0;
      else if (tick && m_timer < 255) m_timer = m_timer + 1;
      m_page = nxt;
    end
  end

  always @(posedge clk) begin
    #2;
    if (model_on) begin
      check_output("state", 32'(state), 32'(m_page * 16));
      check_output("player_instr", 32'(player_instr), 32'(e_instr));
      check_output("is_move", 32'(is_move), 32'(e_move));
      check_output("start_dmg", 32'(start_dmg), 32'(e_sdmg));
      check_output("mon_hp", 32'(mon_hp), 32'(m_mon));
      check_output("atk_start", 32'(atk_start), 32'(e_start));
      check_output("atk_button", 32'(atk_button), 32'(e_button));
      check_output("atk_reset", 32'(atk_reset), 32'(e_areset));
      check_output("bullet_run", 32'(bullet_run), 32'(e_brun));
      check_output("mercy", 32'(mercy), 32'(m_mercy));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] k);
    @(negedge clk) key = k;
    @(negedge clk) key = 4'd0;
  endtask

  task automatic start_game();
    pulse_ticks(3);
    apply_stimulus(4'd8);
  endtask

  task automatic to_action();
    pulse_ticks(7);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(2);
    model_on = 1'b1;
    check_output("lit_reset_state", 32'(state), 32'h10);
    check_output("lit_reset_atk_reset", 32'(atk_reset), 32'h1);
    check_output("lit_reset_instr", 32'(player_instr), 32'h0);
    reset = 1'b0;

    pulse_ticks(1);
    apply_stimulus(4'd8);
    check_output("lit_early_space", 32'(state), 32'h10);
    pulse_ticks(2);
    apply_stimulus(4'd8);
    check_output("lit_start_state", 32'(state), 32'h90);
    check_output("lit_start_instr", 32'(player_instr), 32'h6640);
    check_output("lit_start_bullet", 32'(bullet_run), 32'h1);

    @(negedge clk) key = 4'd1;
    repeat (5) begin
      @(negedge clk);
      check_output("lit_hold_w_instr", 32'(player_instr), 32'h5000);
      check_output("lit_hold_w_move", 32'(is_move), 32'h1);
    end
    key = 4'd0;
    @(negedge clk) key = 4'd4;
    @(negedge clk) key = 4'd0;
    check_output("lit_move_right", 32'(player_instr), 32'h5030);

    @(negedge clk) begin dmg_complete = 1'b1; damage = 8'h0C; end
    @(negedge clk) dmg_complete = 1'b0;
    check_output("lit_dpy_instr", 32'(player_instr), 32'h20C0);
    check_output("lit_dpy_pulse", 32'(start_dmg), 32'h1);
    @(negedge clk);
    check_output("lit_dpy_pulse_end", 32'(start_dmg), 32'h0);
    @(negedge clk) begin dmg_complete = 1'b1; heal = 1'b1; end
    @(negedge clk) begin dmg_complete = 1'b0; heal = 1'b0; end
    check_output("lit_hpy_instr", 32'(player_instr), 32'h10A0);

    pulse_ticks(6);
    @(negedge clk) begin tick = 1'b1; is_death = 1'b1; end
    @(negedge clk) begin tick = 1'b0; is_death = 1'b0; end
    check_output("lit_lose_state", 32'(state), 32'h30);
    pulse_ticks(3);
    check_output("lit_lose_hold", 32'(state), 32'h30);
    idle(1);
    check_output("lit_lose_to_menu", 32'(state), 32'h10);

    start_game();
    to_action();
    apply_stimulus(4'd5);
    check_output("lit_atk_start", 32'(atk_start), 32'h1);
    check_output("lit_atk_reset_low", 32'(atk_reset), 32'h0);
    @(negedge clk) key = 4'd8;
    idle(3);
    key = 4'd0;
    check_output("lit_atk_button", 32'(atk_button), 32'h1);
    @(negedge clk) begin atk_pass = 1'b1; dmg_mon = 8'd60; end
    @(negedge clk) atk_pass = 1'b0;
    check_output("lit_hit1_hp", 32'(mon_hp), 32'd60);
    check_output("lit_hit1_state", 32'(state), 32'h90);
    check_output("lit_hit1_atk_reset", 32'(atk_reset), 32'h1);
    to_action();
    apply_stimulus(4'd5);
    @(negedge clk) begin atk_pass = 1'b1; dmg_mon = 8'd60; end
    @(negedge clk) atk_pass = 1'b0;
    check_output("lit_hit2_hp", 32'(mon_hp), 32'd100);
    check_output("lit_hit2_state", 32'(state), 32'h20);
    check_output("lit_hit2_atk_reset", 32'(atk_reset), 32'h1);
    apply_stimulus(4'd5);
    check_output("lit_win_ignores_keys", 32'(state), 32'h20);
    pulse_ticks(3);
    idle(1);

    start_game();
    check_output("lit_newgame_hp", 32'(mon_hp), 32'd0);
    to_action();
    apply_stimulus(4'd5);
    pulse_ticks(4);
    check_output("lit_timeout_hold", 32'(state), 32'hB0);
    idle(1);
    check_output("lit_timeout_state", 32'(state), 32'h90);
    check_output("lit_timeout_hp", 32'(mon_hp), 32'd0);
    check_output("lit_timeout_atk_reset", 32'(atk_reset), 32'h1);

    to_action();
    apply_stimulus(4'd7);
    check_output("lit_l_no_mercy", 32'(state), 32'h90);
    to_action();
    apply_stimulus(4'd6);
    check_output("lit_check_state", 32'(state), 32'hC0);
    apply_stimulus(4'd8);
    to_action();
    apply_stimulus(4'd7);
    check_output("lit_mercy_early", 32'(mercy), 32'h0);
    to_action();
    idle(1);
    check_output("lit_mercy_set", 32'(mercy), 32'h1);
    apply_stimulus(4'd7);
    check_output("lit_spare_win", 32'(state), 32'h20);
    pulse_ticks(3);
    idle(1);

    start_game();
    to_action();
    apply_stimulus(4'd5);
    apply_stimulus(4'd8);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_output("lit_midreset_state", 32'(state), 32'h10);
    check_output("lit_midreset_start", 32'(atk_start), 32'h0);
    check_output("lit_midreset_button", 32'(atk_button), 32'h0);
    check_output("lit_midreset_atk_reset", 32'(atk_reset), 32'h1);
    check_output("lit_midreset_hp", 32'(mon_hp), 32'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
